// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: master, host, RAM and IO signals seen by the bus arbiter
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH     = 8,
    parameter int IO_SEL_WIDTH   = 3
);
    logic                              host_active;
    logic [RAM_ADDR_WIDTH-1:0]         host_addr;
    logic                              host_wr;
    logic [DATA_WIDTH-1:0]             host_dout;
    logic [DATA_WIDTH-1:0]             host_din;
    logic [NUM_MASTERS-1:0]            m_req;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS-1:0]            m_wr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout;
    logic [NUM_MASTERS-1:0]            m_gnt;
    logic [NUM_MASTERS-1:0]            m_rvalid;
    logic [DATA_WIDTH-1:0]             m_din;
    logic                              ram_we;
    logic [RAM_ADDR_WIDTH-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]             ram_din;
    logic [DATA_WIDTH-1:0]             ram_dout;
    logic                              io_en;
    logic [IO_SEL_WIDTH-1:0]           io_sel;
    logic                              io_wr;
    logic [DATA_WIDTH-1:0]             io_din;
    logic [DATA_WIDTH-1:0]             io_dout;
    logic                              io_full;

    modport slave (
        input  host_active, host_addr, host_wr, host_dout, m_req, m_addr, m_wr, m_dout,
               ram_dout, io_dout, io_full,
        output host_din, m_gnt, m_rvalid, m_din, ram_we, ram_addr, ram_din,
               io_en, io_sel, io_wr, io_din
    );

    modport master (
        output host_active, host_addr, host_wr, host_dout, m_req, m_addr, m_wr, m_dout,
               ram_dout, io_dout, io_full,
        input  host_din, m_gnt, m_rvalid, m_din, ram_we, ram_addr, ram_din,
               io_en, io_sel, io_wr, io_din
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin RAM/IO arbiter for N masters with host override and IO back-pressure
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH     = 8,
    parameter int IO_SEL_WIDTH   = 3
) (
    input logic              clk,
    input logic              rst_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_MASTERS) + 1;

    logic [NUM_MASTERS-1:0]    is_io, elig, gnt, rvalid_q;
    logic [PW-1:0]             ptr_q, ptr_d, idx;
    logic                      found, sel_io, sel_wr, src_io_q;
    logic [RAM_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_dout;

    // region decode per master; an IO write is held back while the IO buffer is full
    always_comb begin
        is_io = '0;
        elig  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            is_io[i] = bus.m_addr[i*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2] == 2'b11;
            elig[i]  = bus.m_req[i] && !(is_io[i] && bus.m_wr[i] && bus.io_full);
        end
    end

    // scan upward from the pointer (wrapping) and grant the first eligible master
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = ptr_q + PW'(k);
            idx = (idx >= PW'(NUM_MASTERS)) ? idx - PW'(NUM_MASTERS) : idx;
            for (int i = 0; i < NUM_MASTERS; i++)
                if (!found && !bus.host_active && elig[i] && idx == PW'(i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                    ptr_d  = (i == NUM_MASTERS - 1) ? '0 : PW'(i + 1);
                end
        end
    end

    // pick the granted master's request fields; gnt is one-hot or zero
    always_comb begin
        sel_addr = '0;
        sel_dout = '0;
        sel_wr   = 1'b0;
        sel_io   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (gnt[i]) begin
                sel_addr = bus.m_addr[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
                sel_dout = bus.m_dout[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wr   = bus.m_wr[i];
                sel_io   = is_io[i];
            end
    end

    // steer the cycle's access to the host, RAM or IO; no access decodes to all-zero
    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        bus.io_en    = 1'b0;
        bus.io_sel   = '0;
        bus.io_wr    = 1'b0;
        bus.io_din   = '0;
        if (bus.host_active) begin
            bus.ram_we   = bus.host_wr;
            bus.ram_addr = bus.host_addr;
            bus.ram_din  = bus.host_dout;
        end else if (found && sel_io) begin
            bus.io_en  = 1'b1;
            bus.io_sel = sel_addr[IO_SEL_WIDTH-1:0];
            bus.io_wr  = sel_wr;
            bus.io_din = sel_dout;
        end else if (found) begin
            bus.ram_we   = sel_wr;
            bus.ram_addr = sel_addr;
            bus.ram_din  = sel_dout;
        end
    end

    // advance the pointer past the winner, pipeline read-valid, remember where read data comes from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            src_io_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= sel_wr ? '0 : gnt;
            if (found)
                src_io_q <= sel_io;
        end
    end

    assign bus.m_gnt    = gnt;
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_din    = src_io_q ? bus.io_dout : bus.ram_dout;
    assign bus.host_din = bus.ram_dout;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table, reset corner cases and random traffic against a reference model
module tb_mem_bus_arbiter;
    localparam int N = 2, AW = 32, RW = 17, DW = 8, SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW),
                         .DATA_WIDTH(DW), .IO_SEL_WIDTH(SW)) bus ();
    mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW),
                      .DATA_WIDTH(DW), .IO_SEL_WIDTH(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [DW-1:0] mem     [0:(1<<RW)-1];
    logic [DW-1:0] ref_mem [0:(1<<RW)-1];
    logic [DW-1:0] io_reg  [0:(1<<SW)-1];
    logic [DW-1:0] ref_io  [0:(1<<SW)-1];
    int checks = 0, failures = 0, ptr = 0;
    logic [N-1:0]  exp_rv = '0;
    logic [DW-1:0] exp_din = '0;

    typedef struct packed {
        logic          host, hwr;
        logic [RW-1:0] haddr;
        logic [DW-1:0] hdout;
        logic [N-1:0]  req, wr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          full;
        logic [N-1:0]  e_gnt;
        logic          e_we, e_io;
        logic [N-1:0]  e_rv;
        logic [DW-1:0] e_din;
    } vec_t;
    vec_t tbl [15];

    // environment: sync single-port RAM and IO register file, both one-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
        if (bus.io_en && bus.io_wr) io_reg[bus.io_sel] <= bus.io_din;
        if (bus.io_en && !bus.io_wr) bus.io_dout <= io_reg[bus.io_sel];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_io(input logic [AW-1:0] a);
        return ((a >> (RW - 1)) & 3) == 3;
    endfunction

    // reference: decide the winner from the rules, compare the decode, then commit its effects
    task automatic eval();
        int g;
        logic [AW-1:0] a;
        logic [N-1:0] eg;
        logic [DW-1:0] d;
        logic w;
        #1;
        g = -1;
        if (!bus.host_active)
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                a = bus.m_addr[i*AW +: AW];
                if (g < 0 && bus.m_req[i] && !(in_io(a) && bus.m_wr[i] && bus.io_full)) g = i;
            end
        eg = (g < 0) ? '0 : N'(1) << g;
        chk("m_gnt", bus.m_gnt, eg);
        exp_rv = '0;
        if (bus.host_active) begin
            chk("host ram_we", bus.ram_we, bus.host_wr);
            chk("host ram_addr", bus.ram_addr, bus.host_addr);
            chk("host io_en", bus.io_en, 0);
            if (bus.host_wr) begin
                chk("host ram_din", bus.ram_din, bus.host_dout);
                ref_mem[bus.host_addr] = bus.host_dout;
            end
        end else if (g < 0) begin
            chk("idle ram_we", bus.ram_we, 0);
            chk("idle io_en", bus.io_en, 0);
            chk("idle io_wr", bus.io_wr, 0);
            chk("idle ram_addr", bus.ram_addr, 0);
            chk("idle io_sel", bus.io_sel, 0);
        end else begin
            a = bus.m_addr[g*AW +: AW];
            w = bus.m_wr[g];
            d = bus.m_dout[g*DW +: DW];
            ptr = (g + 1) % N;
            if (in_io(a)) begin
                chk("io io_en", bus.io_en, 1);
                chk("io io_sel", bus.io_sel, a % (1 << SW));
                chk("io io_wr", bus.io_wr, w);
                chk("io ram_we", bus.ram_we, 0);
                if (w) begin
                    chk("io io_din", bus.io_din, d);
                    ref_io[a % (1 << SW)] = d;
                end else begin
                    exp_rv = eg;
                    exp_din = ref_io[a % (1 << SW)];
                end
            end else begin
                chk("ram ram_addr", bus.ram_addr, a % (1 << RW));
                chk("ram ram_we", bus.ram_we, w);
                chk("ram io_en", bus.io_en, 0);
                if (w) begin
                    chk("ram ram_din", bus.ram_din, d);
                    ref_mem[a % (1 << RW)] = d;
                end else begin
                    exp_rv = eg;
                    exp_din = ref_mem[a % (1 << RW)];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("m_rvalid", bus.m_rvalid, exp_rv);
        if (exp_rv != 0) chk("m_din", bus.m_din, exp_din);
        chk("host_din", bus.host_din, bus.ram_dout);
    endtask

    task automatic set_in(input vec_t v);
        bus.host_active = v.host;
        bus.host_wr = v.hwr;
        bus.host_addr = v.haddr;
        bus.host_dout = v.hdout;
        bus.m_req = v.req;
        bus.m_wr = v.wr;
        bus.m_addr = {v.a1, v.a0};
        bus.m_dout = {v.d1, v.d0};
        bus.io_full = v.full;
    endtask

    initial begin
        // host hwr haddr hdout req wr a0 a1 d0 d1 full | gnt we io rv din
        tbl = '{
            '{0, 0, 0, 0, 2'b11, 2'b00, 'h100, 'h200, 0, 0, 0, 2'b01, 0, 0, 2'b00, 0},
            '{0, 0, 0, 0, 2'b11, 2'b00, 'h100, 'h200, 0, 0, 0, 2'b10, 0, 0, 2'b01, 'hA5},
            '{0, 0, 0, 0, 2'b11, 2'b00, 'h100, 'h200, 0, 0, 0, 2'b01, 0, 0, 2'b10, 'h5A},
            '{0, 0, 0, 0, 2'b11, 2'b00, 'h100, 'h200, 0, 0, 0, 2'b10, 0, 0, 2'b01, 'hA5},
            '{0, 0, 0, 0, 2'b10, 2'b10, 0, 'h30000, 0, 'h41, 0, 2'b10, 0, 1, 2'b10, 'h5A},
            '{0, 0, 0, 0, 2'b01, 2'b00, 'h30004, 0, 0, 0, 0, 2'b01, 0, 1, 2'b00, 0},
            '{0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 'hD2},
            '{0, 0, 0, 0, 2'b11, 2'b01, 'h30001, 'h100, 'h99, 0, 1, 2'b10, 0, 0, 2'b00, 0},
            '{0, 0, 0, 0, 2'b11, 2'b01, 'h30001, 'h100, 'h99, 0, 1, 2'b10, 0, 0, 2'b10, 'hA5},
            '{0, 0, 0, 0, 2'b11, 2'b01, 'h30001, 'h100, 'h99, 0, 1, 2'b10, 0, 0, 2'b10, 'hA5},
            '{0, 0, 0, 0, 2'b11, 2'b01, 'h30001, 'h100, 'h99, 0, 0, 2'b01, 0, 1, 2'b10, 'hA5},
            '{1, 1, 'h20, 'h77, 2'b11, 2'b00, 'h20, 'h20, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0},
            '{0, 0, 0, 0, 2'b01, 2'b00, 'h20, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 0},
            '{1, 0, 'h100, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 'h77},
            '{0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0}
        };
        for (int i = 0; i < (1 << RW); i++) begin
            mem[i] = DW'(i) ^ 8'h5C;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < (1 << SW); i++) begin
            io_reg[i] = 8'hC0 + DW'(i);
            ref_io[i] = io_reg[i];
        end
        mem[0] = 8'h3C; ref_mem[0] = 8'h3C;
        mem['h100] = 8'hA5; ref_mem['h100] = 8'hA5;
        mem['h200] = 8'h5A; ref_mem['h200] = 8'h5A;
        io_reg[4] = 8'hD2; ref_io[4] = 8'hD2;
        set_in('0);

        // reset state with idle inputs
        repeat (3) @(posedge clk);
        #1;
        chk("rst m_gnt", bus.m_gnt, 0);
        chk("rst m_rvalid", bus.m_rvalid, 0);
        chk("rst ram_we", bus.ram_we, 0);
        chk("rst io_en", bus.io_en, 0);
        chk("rst io_wr", bus.io_wr, 0);
        chk("rst ram_addr", bus.ram_addr, 0);
        chk("rst io_sel", bus.io_sel, 0);
        chk("rst m_din", bus.m_din, ref_mem[0]);
        rst_n = 1'b1;

        // directed table: round-robin, IO decode, back-pressure, host override
        for (int r = 0; r < 15; r++) begin
            set_in(tbl[r]);
            chk($sformatf("row%0d m_rvalid", r), bus.m_rvalid, tbl[r].e_rv);
            if (tbl[r].e_rv != 0) chk($sformatf("row%0d m_din", r), bus.m_din, tbl[r].e_din);
            eval();
            chk($sformatf("row%0d m_gnt", r), bus.m_gnt, tbl[r].e_gnt);
            chk($sformatf("row%0d ram_we", r), bus.ram_we, tbl[r].e_we);
            chk($sformatf("row%0d io_en", r), bus.io_en, tbl[r].e_io);
            tick();
        end

        // reset while an IO read response is on the bus: rvalid drops at once, source returns to RAM
        set_in('0);
        bus.m_req = 2'b01;
        bus.m_addr = {32'h0, 32'h30004};
        eval();
        tick();
        bus.m_req = '0;
        #2;
        rst_n = 1'b0;
        ptr = 0;
        exp_rv = '0;
        #1;
        chk("midrst m_rvalid", bus.m_rvalid, 0);
        chk("midrst m_din", bus.m_din, ref_mem[0]);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // grant master0 read of 0x10, reset before the edge: no response, pointer back to 0
        bus.m_req = 2'b01;
        bus.m_addr = {32'h0, 32'h10};
        eval();
        rst_n = 1'b0;
        ptr = 0;
        exp_rv = '0;
        #1;
        chk("gntrst m_rvalid", bus.m_rvalid, 0);
        bus.m_req = '0;
        @(posedge clk);
        #1;
        chk("gntrst held m_rvalid", bus.m_rvalid, 0);
        rst_n = 1'b1;
        bus.m_req = 2'b11;
        bus.m_addr = {32'h100, 32'h10};
        eval();
        chk("postrst m_gnt", bus.m_gnt, 2'b01);
        tick();

        // random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            logic [AW-1:0] a;
            bus.host_active = ($urandom_range(0, 7) == 0);
            bus.host_wr = 1'($urandom);
            bus.host_addr = RW'($urandom_range(0, 63));
            bus.host_dout = DW'($urandom);
            bus.m_req = N'($urandom);
            bus.m_wr = N'($urandom);
            bus.io_full = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0, 1:    a[17:0] = 18'($urandom_range(0, 63));
                    2:       a[17:0] = 18'h30000 + 18'($urandom_range(0, 7));
                    default: a[17:0] = 18'h10000 + 18'($urandom_range(0, 15));
                endcase
                bus.m_addr[i*AW +: AW] = a;
                bus.m_dout[i*DW +: DW] = DW'($urandom);
            end
            eval();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
